// File: rtl/llc_output_encoder_pkg.sv
// Shared types for the LLC outbound path: message type encoding and the
// outbound packet layout carried on every channel.
package llc_output_encoder_pkg;

   localparam int LLC_OUT_CHANNELS = 5;

   localparam int COH_MSG_W   = 5;
   localparam int HPROT_W     = 2;
   localparam int LINE_ADDR_W = 28;
   localparam int LINE_W      = 128;
   localparam int CACHE_ID_W  = 4;
   localparam int WORD_OFF_W  = 2;

   typedef logic [LINE_ADDR_W-1:0] line_addr_t;
   typedef logic [LINE_W-1:0]      line_t;
   typedef logic [CACHE_ID_W-1:0]  cache_id_t;

   typedef enum logic [2:0] {
      LLC_OUT_RSP      = 3'd0,
      LLC_OUT_FWD      = 3'd1,
      LLC_OUT_MEM      = 3'd2,
      LLC_OUT_DMA_RSP  = 3'd3,
      LLC_OUT_RST_DONE = 3'd4
   } llc_out_type_t;

   typedef struct packed {
      logic [COH_MSG_W-1:0]  coh_msg;
      logic [HPROT_W-1:0]    hprot;
      line_addr_t            addr;
      line_t                 line;
      cache_id_t             req_id;
      cache_id_t             dest_id;
      logic [WORD_OFF_W-1:0] word_offset;
      logic [WORD_OFF_W-1:0] valid_words;
   } llc_out_packet_t;

endpackage

// File: rtl/llc_output_encoder_if.sv
// Pipeline-side send port plus the five outbound valid/ready channels and
// the status flags of the LLC output encoder.
interface llc_output_encoder_if;
   import llc_output_encoder_pkg::*;

   logic            send_valid;
   logic [2:0]      send_type;
   llc_out_packet_t send_pkt;
   logic            send_ready;

   logic            llc_rsp_out_valid, llc_rsp_out_ready;
   llc_out_packet_t llc_rsp_out_pkt;
   logic            llc_fwd_out_valid, llc_fwd_out_ready;
   llc_out_packet_t llc_fwd_out_pkt;
   logic            llc_mem_req_valid, llc_mem_req_ready;
   llc_out_packet_t llc_mem_req_pkt;
   logic            llc_dma_rsp_out_valid, llc_dma_rsp_out_ready;
   llc_out_packet_t llc_dma_rsp_out_pkt;
   logic            llc_rst_tb_done_valid, llc_rst_tb_done_ready;
   llc_out_packet_t llc_rst_tb_done_pkt;

   logic            idle;
   logic            err_bad_type;

   modport master (
      output send_valid, send_type, send_pkt,
      input  send_ready,
      input  llc_rsp_out_valid, llc_rsp_out_pkt, output llc_rsp_out_ready,
      input  llc_fwd_out_valid, llc_fwd_out_pkt, output llc_fwd_out_ready,
      input  llc_mem_req_valid, llc_mem_req_pkt, output llc_mem_req_ready,
      input  llc_dma_rsp_out_valid, llc_dma_rsp_out_pkt, output llc_dma_rsp_out_ready,
      input  llc_rst_tb_done_valid, llc_rst_tb_done_pkt, output llc_rst_tb_done_ready,
      input  idle, err_bad_type
   );

   modport slave (
      input  send_valid, send_type, send_pkt,
      output send_ready,
      output llc_rsp_out_valid, llc_rsp_out_pkt, input llc_rsp_out_ready,
      output llc_fwd_out_valid, llc_fwd_out_pkt, input llc_fwd_out_ready,
      output llc_mem_req_valid, llc_mem_req_pkt, input llc_mem_req_ready,
      output llc_dma_rsp_out_valid, llc_dma_rsp_out_pkt, input llc_dma_rsp_out_ready,
      output llc_rst_tb_done_valid, llc_rst_tb_done_pkt, input llc_rst_tb_done_ready,
      output idle, err_bad_type
   );

endinterface

// File: rtl/llc_output_encoder_fifo.sv
// Per-channel output FIFO: head is read straight from storage registers, so a
// push becomes visible one cycle later at the earliest (no fall-through).
module llc_out_fifo
   import llc_output_encoder_pkg::*;
#(
   parameter int FIFO_DEPTH = 2,
   localparam int AW = $clog2(FIFO_DEPTH),
   localparam int CW = AW + 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            push,
   input  llc_out_packet_t din,
   input  logic            ready,
   output logic            valid,
   output llc_out_packet_t dout,
   output logic [CW-1:0]   count
);

   llc_out_packet_t mem [FIFO_DEPTH];
   logic [AW-1:0]   rptr, wptr;
   logic            pop;

   assign valid = (count != '0);
   assign pop   = valid & ready;
   assign dout  = mem[rptr];

   // Storage and pointers; power-of-two depth lets the pointers wrap naturally.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rptr  <= '0;
         wptr  <= '0;
         count <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      end else begin
         if (push) begin
            mem[wptr] <= din;
            wptr      <= wptr + 1'b1;
         end
         if (pop) rptr <= rptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/llc_output_encoder.sv
// LLC outbound encoder: decodes the message type, steers it into one of five
// channel FIFOs, and reports back-pressure, idle and illegal-type status.
module llc_output_encoder
   import llc_output_encoder_pkg::*;
#(
   parameter int FIFO_DEPTH = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   llc_output_encoder_if.slave  bus
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam int NCH = LLC_OUT_CHANNELS;

   logic                  legal, sel_full, send_ready, accept, all_empty, err_q;
   logic [NCH-1:0]        push, ch_full, ch_ready, ch_valid;
   logic [CW-1:0]         ch_cnt [NCH];
   llc_out_packet_t       ch_pkt [NCH];

   assign legal = (bus.send_type <= LLC_OUT_RST_DONE);

   // Back-pressure looks only at registered counts, never at the *_ready inputs.
   always_comb begin
      sel_full = 1'b0;
      for (int i = 0; i < NCH; i++)
         if (bus.send_type == 3'(i)) sel_full = ch_full[i];
   end

   assign send_ready     = ~legal | ~sel_full;
   assign accept         = bus.send_valid & send_ready & legal;
   assign bus.send_ready = send_ready;

   assign ch_ready[0] = bus.llc_rsp_out_ready;
   assign ch_ready[1] = bus.llc_fwd_out_ready;
   assign ch_ready[2] = bus.llc_mem_req_ready;
   assign ch_ready[3] = bus.llc_dma_rsp_out_ready;
   assign ch_ready[4] = bus.llc_rst_tb_done_ready;

   for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
      assign push[gi]    = accept & (bus.send_type == 3'(gi));
      assign ch_full[gi] = (ch_cnt[gi] == CW'(FIFO_DEPTH));

      llc_out_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
         .clk   (clk),
         .rst   (rst),
         .push  (push[gi]),
         .din   (bus.send_pkt),
         .ready (ch_ready[gi]),
         .valid (ch_valid[gi]),
         .dout  (ch_pkt[gi]),
         .count (ch_cnt[gi])
      );
   end

   assign bus.llc_rsp_out_valid     = ch_valid[0];
   assign bus.llc_rsp_out_pkt       = ch_pkt[0];
   assign bus.llc_fwd_out_valid     = ch_valid[1];
   assign bus.llc_fwd_out_pkt       = ch_pkt[1];
   assign bus.llc_mem_req_valid     = ch_valid[2];
   assign bus.llc_mem_req_pkt       = ch_pkt[2];
   assign bus.llc_dma_rsp_out_valid = ch_valid[3];
   assign bus.llc_dma_rsp_out_pkt   = ch_pkt[3];
   assign bus.llc_rst_tb_done_valid = ch_valid[4];
   assign bus.llc_rst_tb_done_pkt   = ch_pkt[4];

   always_comb begin
      all_empty = 1'b1;
      for (int i = 0; i < NCH; i++)
         if (ch_cnt[i] != '0) all_empty = 1'b0;
   end

   assign bus.idle = all_empty & ~accept;

   // Illegal types are consumed and dropped; the flag holds until reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                             err_q <= 1'b0;
      else if (bus.send_valid & ~legal)     err_q <= 1'b1;
   end

   assign bus.err_bad_type = err_q;

endmodule

// File: tb/tb_llc_output_encoder.sv
// Directed bench for llc_output_encoder: single send, fill/back-pressure,
// channel isolation, ordering with wrap, illegal type and mid-run reset.
module tb_llc_output_encoder;
   import llc_output_encoder_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_checks = 0;
   int   n_errors = 0;

   llc_output_encoder_if bus ();

   llc_output_encoder #(.FIFO_DEPTH(2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [2:0] t, input logic [27:0] a);
      bus.send_valid    = v;
      bus.send_type     = t;
      bus.send_pkt      = '0;
      bus.send_pkt.addr = a;
   endtask

   task automatic readies(input logic [4:0] r);
      bus.llc_rsp_out_ready     = r[0];
      bus.llc_fwd_out_ready     = r[1];
      bus.llc_mem_req_ready     = r[2];
      bus.llc_dma_rsp_out_ready = r[3];
      bus.llc_rst_tb_done_ready = r[4];
   endtask

   function automatic logic [4:0] valids();
      return {bus.llc_rst_tb_done_valid, bus.llc_dma_rsp_out_valid, bus.llc_mem_req_valid,
              bus.llc_fwd_out_valid, bus.llc_rsp_out_valid};
   endfunction

   initial begin
      int nxt_push;
      int nxt_pop;
      drive(1'b0, 3'd0, 28'h0);
      readies(5'b0);

      // Reset state
      #12;
      check("rst_valids", 128'(valids()), 128'h0);
      check("rst_idle", 128'(bus.idle), 128'h1);
      check("rst_err", 128'(bus.err_bad_type), 128'h0);
      check("rst_pkt", 128'(bus.llc_mem_req_pkt.addr), 128'h0);
      check("rst_send_ready", 128'(bus.send_ready), 128'h1);
      step();
      rst = 1'b1;

      // Single send on mem_req
      step();
      drive(1'b1, 3'd2, 28'h1A3);
      readies(5'b00100);
      @(negedge clk);
      check("single_ready", 128'(bus.send_ready), 128'h1);
      check("single_idle_push", 128'(bus.idle), 128'h0);
      step();
      drive(1'b0, 3'd0, 28'h0);
      @(negedge clk);
      check("single_valid", 128'(bus.llc_mem_req_valid), 128'h1);
      check("single_addr", 128'(bus.llc_mem_req_pkt.addr), 128'h1A3);
      check("single_idle_busy", 128'(bus.idle), 128'h0);
      step();
      @(negedge clk);
      check("single_popped", 128'(bus.llc_mem_req_valid), 128'h0);
      check("single_idle_after", 128'(bus.idle), 128'h1);

      // Fill rsp channel with ready low
      step();
      readies(5'b0);
      drive(1'b1, 3'd0, 28'h1);
      @(negedge clk);
      check("fill_ready1", 128'(bus.send_ready), 128'h1);
      step();
      drive(1'b1, 3'd0, 28'h2);
      @(negedge clk);
      check("fill_ready2", 128'(bus.send_ready), 128'h1);
      step();
      drive(1'b1, 3'd0, 28'h3);
      @(negedge clk);
      check("fill_full", 128'(bus.send_ready), 128'h0);
      check("fill_head", 128'(bus.llc_rsp_out_pkt.addr), 128'h1);
      step();
      readies(5'b00001);
      @(negedge clk);
      check("fill_pop_same_cycle", 128'(bus.send_ready), 128'h0);
      step();
      @(negedge clk);
      check("fill_accept_after_pop", 128'(bus.send_ready), 128'h1);
      check("fill_head2", 128'(bus.llc_rsp_out_pkt.addr), 128'h2);
      step();
      drive(1'b0, 3'd0, 28'h0);
      @(negedge clk);
      check("fill_head3", 128'(bus.llc_rsp_out_pkt.addr), 128'h3);
      check("fill_valid3", 128'(bus.llc_rsp_out_valid), 128'h1);
      step();
      @(negedge clk);
      check("fill_drained", 128'(bus.llc_rsp_out_valid), 128'h0);

      // Isolation: rsp full and stalled, fwd still accepted
      step();
      readies(5'b0);
      drive(1'b1, 3'd0, 28'h10);
      step();
      drive(1'b1, 3'd0, 28'h11);
      step();
      drive(1'b1, 3'd1, 28'h20);
      @(negedge clk);
      check("iso_ready", 128'(bus.send_ready), 128'h1);
      step();
      drive(1'b0, 3'd0, 28'h0);
      @(negedge clk);
      check("iso_fwd_valid", 128'(bus.llc_fwd_out_valid), 128'h1);
      check("iso_fwd_addr", 128'(bus.llc_fwd_out_pkt.addr), 128'h20);
      check("iso_rsp_stable", 128'(bus.llc_rsp_out_pkt.addr), 128'h10);
      check("iso_rsp_blocked", 128'(bus.send_ready), 128'h0);
      step();
      readies(5'b00011);
      step();
      step();
      step();
      readies(5'b0);
      @(negedge clk);
      check("iso_idle", 128'(bus.idle), 128'h1);

      // Order and wrap on mem_req with toggling ready
      nxt_push = 1;
      nxt_pop  = 1;
      for (int cyc = 0; cyc < 40 && nxt_pop <= 6; cyc++) begin
         step();
         bus.llc_mem_req_ready = (cyc % 2 == 0);
         if (nxt_push <= 6) drive(1'b1, 3'd2, 28'(nxt_push));
         else               drive(1'b0, 3'd0, 28'h0);
         @(negedge clk);
         if (bus.send_valid && bus.send_ready) nxt_push++;
         if (bus.llc_mem_req_valid && bus.llc_mem_req_ready) begin
            check("order_addr", 128'(bus.llc_mem_req_pkt.addr), 128'(nxt_pop));
            nxt_pop++;
         end
      end
      check("order_count", 128'(nxt_pop), 128'd7);
      step();
      drive(1'b0, 3'd0, 28'h0);
      readies(5'b0);
      @(negedge clk);
      check("order_empty", 128'(bus.idle), 128'h1);

      // Illegal type
      step();
      drive(1'b1, 3'd6, 28'h55);
      @(negedge clk);
      check("bad_ready", 128'(bus.send_ready), 128'h1);
      check("bad_idle", 128'(bus.idle), 128'h1);
      step();
      drive(1'b0, 3'd0, 28'h0);
      @(negedge clk);
      check("bad_err", 128'(bus.err_bad_type), 128'h1);
      check("bad_no_valid", 128'(valids()), 128'h0);
      step();
      @(negedge clk);
      check("bad_err_held", 128'(bus.err_bad_type), 128'h1);

      // Reset with DMA and FWD loaded
      step();
      drive(1'b1, 3'd3, 28'h30);
      step();
      drive(1'b1, 3'd3, 28'h31);
      step();
      drive(1'b1, 3'd1, 28'h40);
      step();
      drive(1'b1, 3'd1, 28'h41);
      step();
      drive(1'b0, 3'd0, 28'h0);
      @(negedge clk);
      check("mid_loaded", 128'(valids()), 128'h0A);
      #2;
      rst = 1'b0;
      #1;
      check("mid_valids", 128'(valids()), 128'h0);
      check("mid_idle", 128'(bus.idle), 128'h1);
      check("mid_err_clr", 128'(bus.err_bad_type), 128'h0);
      check("mid_pkt_clr", 128'(bus.llc_dma_rsp_out_pkt.addr), 128'h0);
      step();
      rst = 1'b1;
      step();
      drive(1'b1, 3'd4, 28'h0);
      bus.send_pkt.line[0] = 1'b1;
      readies(5'b10000);
      step();
      drive(1'b0, 3'd0, 28'h0);
      @(negedge clk);
      check("post_valid", 128'(valids()), 128'h10);
      check("post_line0", 128'(bus.llc_rst_tb_done_pkt.line[0]), 128'h1);
      step();
      @(negedge clk);
      check("post_idle", 128'(bus.idle), 128'h1);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
